// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit processor: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory-ready stalls, HALT, illegal-opcode flag and a retired-instruction counter.
// Optional memory-stall watchdog enabled by defining CU_MEM_TIMEOUT_EN.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_mem_ready,
  output logic                o_pc_write,
  output logic                o_ir_write,
  output logic                o_iord,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic [1:0]          o_reg_dst,
  output logic [1:0]          o_mem_to_reg,
  output logic [1:0]          o_alu_op,
  output logic                o_alu_src,
  output logic                o_reg_write,
  output logic                o_branch,
  output logic                o_jump,
  output logic                o_sign_or_zero,
  output logic                o_busy,
  output logic                o_illegal,
  output logic                o_mem_timeout,
  output logic [CNT_W-1:0]    o_retired,
  output logic [2:0]          o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_SLTI = 3'd1;
  localparam logic [2:0] OP_J    = 3'd2;
  localparam logic [2:0] OP_JAL  = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_ADDI = 3'd7;

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic [OPCODE_W-1:0] r_op_q;
  logic [CNT_W-1:0]    r_retired;
  logic [OPCODE_W-1:0] w_dec_op;
  logic [2:0]          w_op3;
  logic                w_halt_op;
  logic                w_illegal_op;
  logic                w_retire;
  logic                w_timeout;

  // op_q only becomes valid after the DECODE edge, so DECODE itself looks at the live opcode.
  assign w_dec_op     = (r_state == S_DECODE) ? i_opcode : r_op_q;
  assign w_op3        = w_dec_op[2:0];
  assign w_halt_op    = (OPCODE_W > 3) && (&w_dec_op);
  assign w_illegal_op = (OPCODE_W > 3) && !w_halt_op && (int'(w_dec_op) > 7);

`ifdef CU_MEM_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] r_stall_cnt;
  logic          w_stalling;

  assign w_stalling = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready;
  assign w_timeout  = w_stalling && (r_stall_cnt == TW'(MEM_TIMEOUT - 1));

  // Any cycle that is not a continuing stall leaves the counter at zero for the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_stall_cnt <= '0;
    else if (w_stalling && !w_timeout) r_stall_cnt <= r_stall_cnt + 1'b1;
    else                             r_stall_cnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_next         = r_state;
    w_retire       = 1'b0;
    o_pc_write     = 1'b0;
    o_ir_write     = 1'b0;
    o_iord         = 1'b0;
    o_mem_read     = 1'b0;
    o_mem_write    = 1'b0;
    o_reg_dst      = 2'd0;
    o_mem_to_reg   = 2'd0;
    o_alu_op       = 2'b00;
    o_alu_src      = 1'b0;
    o_reg_write    = 1'b0;
    o_branch       = 1'b0;
    o_jump         = 1'b0;
    o_sign_or_zero = 1'b1;
    o_illegal      = 1'b0;
    o_mem_timeout  = 1'b0;
    case (r_state)
      S_IDLE, S_HALTED: if (i_start) w_next = S_FETCH;
      S_FETCH: begin
        if (w_timeout) begin
          o_mem_timeout = 1'b1;
          w_next        = S_HALTED;
        end else begin
          o_mem_read = 1'b1;
          if (i_mem_ready) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            w_next     = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (w_halt_op) begin
          w_next = S_HALTED;
        end else if (w_illegal_op) begin
          o_illegal = 1'b1;
          w_next    = S_FETCH;
        end else if (w_op3 == OP_J || w_op3 == OP_JAL) begin
          o_jump     = 1'b1;
          o_pc_write = 1'b1;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
          if (w_op3 == OP_JAL) begin
            o_reg_write  = 1'b1;
            o_reg_dst    = 2'd2;
            o_mem_to_reg = 2'd2;
          end
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_op3)
          OP_BEQ:               o_alu_op = 2'b01;
          OP_SLTI:              o_alu_op = 2'b10;
          OP_LW, OP_SW, OP_ADDI: o_alu_op = 2'b11;
          default:              o_alu_op = 2'b00;
        endcase
        o_alu_src      = (w_op3 == OP_SLTI) || (w_op3 == OP_LW) ||
                         (w_op3 == OP_SW)   || (w_op3 == OP_ADDI);
        o_sign_or_zero = (w_op3 != OP_SLTI);
        o_branch       = (w_op3 == OP_BEQ);
        if (w_op3 == OP_BEQ) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_op3 == OP_LW || w_op3 == OP_SW) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (w_timeout) begin
          o_mem_timeout = 1'b1;
          w_next        = S_HALTED;
        end else begin
          o_iord      = 1'b1;
          o_mem_read  = (w_op3 == OP_LW);
          o_mem_write = (w_op3 == OP_SW);
          if (i_mem_ready) begin
            w_retire = (w_op3 == OP_SW);
            w_next   = (w_op3 == OP_LW) ? S_WB : S_FETCH;
          end
        end
      end
      S_WB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = (w_op3 == OP_R)  ? 2'd1 : 2'd0;
        o_mem_to_reg = (w_op3 == OP_LW) ? 2'd1 : 2'd0;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op_q    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= i_opcode;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  assign o_busy    = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign o_retired = r_retired;
  assign o_state   = r_state;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle, parametrised control FSM for the 16-bit microprocessor. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on a memory ready handshake and flags illegal opcodes. It supports HALT and counts retired instructions. It sits between the instruction register and the datapath and drives the datapath mux selects and write strobes.

## Interface
- `OPCODE_W`, 4: opcode width, legal range 3..6.
- `CNT_W`, 16: width of the retired-instruction counter.
- `MEM_TIMEOUT`, 15: maximum stall cycles per memory access. Used only when `CU_MEM_TIMEOUT_EN` is defined.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE/HALTED and begin fetching.
- `opcode`  in  OPCODE_W  instruction register opcode field. Valid from DECODE onwards.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`, `ir_write`, `iord`  out  1  PC update, IR load, address select (0 = PC, 1 = ALU result).
- `mem_read`, `mem_write`  out  1  memory strobes.
- `reg_dst`, `mem_to_reg`, `alu_op`  out  2  encodings:
  - `reg_dst`: 1 = R-type, 2 = JAL.
  - `mem_to_reg`: 1 = LW, 2 = JAL.
  - `alu_op`: 00 = R/J, 01 = BEQ, 10 = SLTI, 11 = LW/SW/ADDI.
- `alu_src`, `reg_write`, `branch`, `jump`, `sign_or_zero`  out  1  same meanings as the single-cycle decoder. `sign_or_zero` = 0 only for SLTI.
- `busy`  out  1  state is neither IDLE nor HALTED.
- `illegal`  out  1  one-cycle pulse on an illegal opcode.
- `mem_timeout`  out  1  one-cycle pulse when a stall exceeds `MEM_TIMEOUT`.
- `retired`  out  CNT_W  count of completed legal instructions.
- `state`  out  3  encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALTED = 6.

## Operation
- Opcode map:
  - 0 = R-type, 1 = SLTI, 2 = J, 3 = JAL, 4 = LW, 5 = SW, 6 = BEQ, 7 = ADDI.
  - When `OPCODE_W` > 3, all-ones = HALT. Any other value > 7 is illegal.
- In DECODE, `opcode` is latched into `op_q`. All later states decode from `op_q` only.
- IDLE: all strobes 0. If `start` = 1, go to FETCH.
- FETCH: `mem_read` = 1, `iord` = 0.
  - While `mem_ready` = 0, stay.
  - When `mem_ready` = 1, pulse `ir_write` = 1 and `pc_write` = 1 (PC + 1), then go to DECODE.
- DECODE:
  - J: `jump` = 1, `pc_write` = 1, go to FETCH.
  - JAL: additionally `reg_write` = 1, `reg_dst` = 2, `mem_to_reg` = 2.
  - HALT: go to HALTED.
  - Illegal: pulse `illegal`, no writes, go to FETCH.
  - All others: go to EXEC.
- EXEC: `alu_op`, `alu_src` and `sign_or_zero` take their per-opcode values.
  - BEQ: `branch` = 1, then go to FETCH. The datapath gates the PC write with zero.
  - LW/SW: go to MEM.
  - R/SLTI/ADDI: go to WB.
- MEM: `iord` = 1; `mem_read` (LW) or `mem_write` (SW) held until `mem_ready`.
  - LW: go to WB.
  - SW: go to FETCH.
- WB: `reg_write` = 1 for one cycle.
  - `reg_dst` = 1 for R-type; `mem_to_reg` = 1 for LW.
  - Go to FETCH.
- HALTED: all strobes 0. If `start` = 1, go to FETCH.
- `retired` increments on every transition into FETCH from DECODE/EXEC/MEM/WB, except the illegal path. It wraps modulo 2^CNT_W.
- Outputs are combinational from `state`, `op_q` and `mem_ready`. Non-listed outputs in each state are 0; `sign_or_zero` defaults to 1.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - `state` = IDLE and `op_q` = 0.
  - `retired` = 0 and the stall counter = 0.
  - All outputs 0 except `sign_or_zero` = 1.
  - A reset mid-instruction aborts it with no further strobes.
- Latency with `mem_ready` always 1, FETCH-to-FETCH:
  - J/JAL: 2 cycles.
  - BEQ: 3 cycles.
  - SW and R/SLTI/ADDI: 4 cycles.
  - LW: 5 cycles.
- Each stall cycle in FETCH or MEM adds one cycle.
- `mem_read`/`mem_write` are held constant throughout a stall.
- `ir_write` and `pc_write` are asserted only in the FETCH cycle where `mem_ready` = 1.
- `start` is ignored outside IDLE/HALTED.
- `mem_ready` is ignored outside FETCH/MEM.

## Configuration
- `CU_MEM_TIMEOUT_EN` defined:
  - A stall counter clears on entry to FETCH/MEM and increments each cycle `mem_ready` = 0.
  - When it reaches `MEM_TIMEOUT`: pulse `mem_timeout`, drop strobes and go to HALTED.
  - No IR/PC/register write occurs on that cycle.
- `CU_MEM_TIMEOUT_EN` undefined: stalls are unbounded, `mem_timeout` is tied to 0, and no counter is built.

## Test plan
- Reset and one-cycle-ready path:
  - Stimulus: reset, `start` = 1, `opcode` = 0, `mem_ready` = 1.
  - Response: state sequence 1,2,3,5,1.
  - `reg_write` = 1 with `reg_dst` = 1 in WB only; `retired` = 1 after 4 cycles.
- LW with 3-cycle MEM stall:
  - Response: `mem_read` = 1 and `iord` = 1 for 4 cycles, then WB with `mem_to_reg` = 1.
  - Total FETCH-to-FETCH = 8 cycles.
- JAL: DECODE asserts `jump` = 1, `pc_write` = 1, `reg_write` = 1, `reg_dst` = 2 and `mem_to_reg` = 2 in one cycle; returns to FETCH.
- Illegal and HALT opcodes:
  - `opcode` = 4'h9: one `illegal` pulse, no writes, `retired` unchanged.
  - `opcode` = 4'hF: reaches HALTED with `busy` = 0.
  - `start` then resumes at FETCH.
- Counter wrap: `CNT_W` = 4, 17 ADDI instructions -> `retired` = 1.
- Timeout (macro defined, `MEM_TIMEOUT` = 15):
  - `mem_ready` held 0 in FETCH -> `mem_timeout` pulses exactly once, on the 15th stall cycle; state = 6.
  - With the macro undefined, the unit remains in FETCH indefinitely.
